// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a PC-tagged buffer and redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into S_FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic        fetch_fault
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_BOOT, S_RUN} state_t;
`endif
    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, rsp_pc, redir_pc;
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, out_cnt, discard_cnt, out_cnt_nxt;
    logic [AW+1:0] occupancy;
    logic          accept, push, pop;
    assign redir_pc       = redirect_pc & 32'hFFFF_FFFC;
    assign occupancy      = (AW+2)'(count) + (AW+2)'(out_cnt);
    assign imem_req_valid = state == S_RUN && occupancy < (AW+2)'(FIFO_DEPTH) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign out_cnt_nxt    = out_cnt + (AW+1)'(accept) - (AW+1)'(imem_rsp_valid);
    assign push           = imem_rsp_valid && discard_cnt == '0 && !redirect_valid;
    assign id_valid       = count != '0;
    assign pop            = id_valid && id_ready;
    assign id_instr       = instr_mem[rd_ptr];
    assign id_pc          = pc_mem[rd_ptr];
    assign id_opcode      = id_instr[6:0];
    assign id_funct3      = id_instr[14:12];
    assign id_funct7      = id_instr[31:25];
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned  = redirect_pc[1:0] != 2'b00;
    assign fetch_fault = state == S_FAULT;
`else
    assign fetch_fault = 1'b0;
`endif
    always_comb begin
        state_nxt = state == S_BOOT ? S_RUN : state;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_valid && state != S_BOOT) state_nxt = misaligned ? S_FAULT : S_RUN;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            out_cnt     <= '0;
            discard_cnt <= '0;
        end else begin
            state   <= state_nxt;
            out_cnt <= out_cnt_nxt;
            if (redirect_valid) begin
                // everything still in flight, minus a response landing now, must be dropped
                fetch_pc    <= redir_pc;
                rsp_pc      <= redir_pc;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                discard_cnt <= out_cnt_nxt;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && discard_cnt != '0) discard_cnt <= discard_cnt - (AW+1)'(1);
                if (push) rsp_pc <= rsp_pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && !pop && count == (AW+1)'(FIFO_DEPTH)));
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against a stream-level fetch model.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_fetch_unit;
    localparam int          D  = 4;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] K  = 32'h5A5A_5A5A;
    logic        clk = 0, reset = 1;
    logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
    logic [31:0] imem_req_addr, imem_rsp_data = 0;
    logic        redirect_valid = 0, id_valid, id_ready = 0, fetch_fault;
    logic [31:0] redirect_pc = 0, id_instr, id_pc;
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;
    always #5 clk = ~clk;
    fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7), .fetch_fault(fetch_fault)
    );
    typedef struct {logic [31:0] addr; int ep; int due;} req_t;
    req_t        mq[$];
    logic [31:0] popped[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, since = 0, ep = 0, buffered = 0, accepts = 0, drops = 0;
    int          lat = 1, rdy_pct = 100, idr_pct = 100;
    bit          rand_lat = 0, rst_req = 1, rd_now = 0, fault_m = 0;
    logic [31:0] rd_tgt = 0, exp_pc = RV, exp_req = RV;
    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask
    // One clock: drive at negedge, compare against the stream model, then advance the model.
    task automatic step();
        bit          acc, rsp, pop, run;
        logic [31:0] ew;
        @(negedge clk);
        reset          = rst_req;
        imem_req_ready = $urandom_range(99) < rdy_pct;
        id_ready       = $urandom_range(99) < idr_pct;
        redirect_valid = rd_now;
        redirect_pc    = rd_tgt;
        rd_now         = 0;
        rsp            = 0;
        if (!reset && mq.size() > 0) rsp = mq[0].due <= cyc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mq[0].addr ^ K : $urandom;
        #1;
        if (!reset) begin
            run = since >= 1 && !fault_m;
            chk("req_valid", 32'(imem_req_valid), 32'(run && (mq.size() + buffered < D) && !redirect_valid));
            chk("id_valid", 32'(id_valid), 32'(buffered > 0));
            chk("fetch_fault", 32'(fetch_fault), 32'(fault_m));
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
            if (id_valid) begin
                ew = exp_pc ^ K;
                chk("id_pc", id_pc, exp_pc);
                chk("id_instr", id_instr, ew);
                chk("id_opcode", 32'(id_opcode), 32'(ew[6:0]));
                chk("id_funct3", 32'(id_funct3), 32'(ew[14:12]));
                chk("id_funct7", 32'(id_funct7), 32'(ew[31:25]));
            end
            acc = imem_req_valid && imem_req_ready;
            pop = id_valid && id_ready;
            if (acc) begin
                mq.push_back('{imem_req_addr, ep, cyc + (rand_lat ? int'($urandom_range(3, 1)) : lat)});
                accepts++;
            end
            if (rsp) begin
                if (mq[0].ep == ep && !redirect_valid) buffered++;
                else drops++;
                void'(mq.pop_front());
            end
            if (redirect_valid) begin
                ep++;
                buffered = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_m = redirect_pc[1:0] != 2'b00;
`endif
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = exp_pc;
            end else begin
                if (pop) begin
                    popped.push_back(id_pc);
                    exp_pc += 4;
                    buffered--;
                end
                if (acc) exp_req += 4;
            end
            since++;
        end else begin
            mq.delete();
            ep++;
            buffered = 0;
            since    = 0;
            fault_m  = 0;
            exp_pc   = RV;
            exp_req  = RV;
        end
        cyc++;
    endtask
    task automatic do_reset();
        rst_req = 1;
        step();
        rst_req = 0;
    endtask
    initial begin
        int n, p0, a0, d0;
        do_reset();
        do_reset();
        step();
        chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
        chk("boot_id_valid", 32'(id_valid), 32'd0);
        chk("boot_fault", 32'(fetch_fault), 32'd0);
        p0 = popped.size();
        n = 0;
        while (!id_valid && n < 20) begin
            step();
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'd3);
        repeat (10) step();
        chk("first_pc", popped[p0], 32'h0);
        chk("second_pc", popped[p0 + 1], 32'h4);
        p0 = popped.size();
        repeat (10) step();
        chk("throughput", 32'(popped.size() - p0), 32'd10);
        idr_pct = 0;
        do_reset();
        a0 = accepts;
        repeat (12) step();
        chk("stall_accepts", 32'(accepts - a0), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_id_pc", id_pc, 32'h0);
        idr_pct = 100;
        p0 = popped.size();
        repeat (4) step();
        for (int i = 0; i < 4; i++) chk("drain_pc", popped[p0 + i], 32'(4 * i));
        lat = 3;
        do_reset();
        repeat (4) step();
        d0 = drops;
        rd_now = 1;
        rd_tgt = 32'h100;
        step();
        p0 = popped.size();
        repeat (14) step();
        chk("redirect_drops", 32'(drops - d0), 32'd3);
        chk("redirect_pc0", popped[p0], 32'h100);
        chk("redirect_pc1", popped[p0 + 1], 32'h104);
        lat = 1;
        rd_now = 1;
        rd_tgt = 32'hFFFF_FFF0;
        step();
        p0 = popped.size();
        repeat (12) step();
        chk("wrap_count", 32'(popped.size() - p0 >= 5), 32'd1);
        chk("wrap_last", popped[p0 + 3], 32'hFFFF_FFFC);
        chk("wrap_zero", popped[p0 + 4], 32'h0);
        rd_now = 1;
        rd_tgt = 32'h102;
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        step();
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_no_req", 32'(imem_req_valid), 32'd0);
        repeat (4) step();
        rd_now = 1;
        rd_tgt = 32'h200;
        step();
        p0 = popped.size();
        repeat (6) step();
        chk("fault_clear", 32'(fetch_fault), 32'd0);
        chk("fault_resume_pc", popped[p0], 32'h200);
`else
        p0 = popped.size();
        repeat (6) step();
        chk("misalign_clear_pc", popped[p0], 32'h100);
`endif
        rdy_pct  = 50;
        idr_pct  = 70;
        rand_lat = 1;
        p0 = popped.size();
        n = 0;
        while (popped.size() - p0 < 200 && n < 20000) begin
            rst_req = n == 300;
            if (since >= 1 && !rst_req && $urandom_range(99) < 3) begin
                rd_now = 1;
                rd_tgt = $urandom_range(3) == 0 ? 32'hFFFF_FFE0 | ($urandom & 32'h1F) : $urandom;
            end
            step();
            n++;
        end
        rst_req = 0;
        chk("random_budget", 32'(n < 20000), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the decode/control stage.
- Owns the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake; the opcode, funct3 and funct7 slices are pre-split for the control decoder.
- Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries and max in-flight requests; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; word aligned.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; responses return in order, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken; 1-cycle pulse.
- redirect_pc  in  32  new fetch target.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts instruction.
- id_instr  out  32  instruction word.
- id_pc  out  32  PC of id_instr.
- id_opcode  out  7  id_instr[6:0].
- id_funct3  out  3  id_instr[14:12].
- id_funct7  out  7  id_instr[31:25].
- fetch_fault  out  1  misaligned redirect fault (feature only; tied 0 otherwise).

Behaviour:
- Reset (clk edge with reset=1):
  - fetch_pc=rsp_pc=RESET_VECTOR; FIFO empty; out_cnt=0; discard_cnt=0; state=S_BOOT.
  - imem_req_valid=0, id_valid=0, fetch_fault=0.
  - Reset mid-operation abandons all in-flight requests.
  - The memory model must also be reset; no responses may arrive after reset.
- FSM states: S_BOOT, S_RUN, S_FAULT (feature only).
  - S_BOOT→S_RUN after one cycle unconditionally.
  - S_RUN→S_FAULT only on a misaligned redirect with the feature enabled.
  - S_FAULT→S_RUN on an aligned redirect.
- Request issue:
  - imem_req_valid = (state==S_RUN) && (fifo_count + out_cnt < FIFO_DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - Accept = valid && ready → fetch_pc += 4 (mod 2^32, wraps), out_cnt++.
  - out_cnt counts every in-flight request, including ones to be discarded.
- Response:
  - Each imem_rsp_valid decrements out_cnt.
  - If discard_cnt>0: decrement discard_cnt and drop the word.
  - Otherwise: push {rsp_pc, data} into the FIFO and increment rsp_pc by 4.
  - Overflow is impossible by the issue rule; an assertion checks it.
- Decode side:
  - id_valid = FIFO non-empty; id_* fields are driven from the FIFO head.
  - Pop on id_valid && id_ready.
  - Simultaneous push and pop are allowed, including when the FIFO is full, since the issue rule reserves space.
  - Head outputs are stable while id_valid && !id_ready.
- Redirect (redirect_valid=1):
  - fetch_pc and rsp_pc ← {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; an id handshake completing the same cycle is still a transfer, and decode squashes it.
  - discard_cnt ← out_cnt + (request accepted this cycle) − (response arriving this cycle). A response arriving this cycle is dropped.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; the discard count is recomputed each time.
- Latency: with 1-cycle memory, id_valid rises 3 cycles after reset deasserts (BOOT, req, rsp, then FIFO head). Sustains 1 instr/cycle when FIFO_DEPTH ≥ memory latency + 2.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]≠0 enters S_FAULT.
  - fetch_fault=1 from the next cycle until an aligned redirect.
  - No requests are issued in S_FAULT; outstanding responses are still discarded; id_valid=0.
- Undefined: low two bits are silently cleared; fetch_fault is tied 0; S_FAULT does not exist.

Test Plan:
- Reset, 1-cycle memory returning addr-tagged words, id_ready=1 → id_pc sequence 0x0,0x4,0x8,…; first id_valid 3 cycles after reset release; one instr/cycle thereafter.
- Hold id_ready=0 for 10 cycles → exactly 4 requests issued, FIFO full, imem_req_valid=0, id_pc stays 0x0; release → 0x0..0xC drain in order.
- 3-cycle memory latency, redirect_pc=0x100 with 3 requests in flight → 3 responses dropped; next id_pc=0x100, then 0x104.
- Redirect in the same cycle as a request accept and a response → discard_cnt matches the formula; no stale PC ever reaches id_pc.
- imem_req_ready toggling 1/0 randomly for 200 instructions vs a reference PC model → no duplicate or missing PCs; fetch_pc wrap from 0xFFFF_FFFC to 0x0 is correct.
- With FETCH_MISALIGN_TRAP_EN: redirect_pc=0x102 → fetch_fault=1, no requests; then redirect 0x200 → fault clears and id_pc=0x200. Without the macro, redirect_pc=0x102 → id_pc=0x100.
